// File: rtl/vx_clone_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vx_clone_sequencer_pkg
// Brief    : Shared state encodings and helpers for the thread-clone sequencer.
// Revision : 1.0
// ============================================================================
package vx_clone_sequencer_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] CLONE_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] CLONE_COPY  = 2'd1;
    localparam logic [STATE_W-1:0] CLONE_DRAIN = 2'd2;
    localparam logic [STATE_W-1:0] CLONE_DONE  = 2'd3;

    localparam int DRAIN_W = 4;

    function automatic int copied_width(input int nt);
        return $clog2(nt) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vx_clone_sequencer_lowest_set.sv
`default_nettype none
// ============================================================================
// Module   : vx_lowest_set
// Brief    : Combinational priority encoder: one-hot of the lowest set bit.
// Revision : 1.0
// ============================================================================
module vx_lowest_set #(
    parameter int W = 4
) (
    input  logic [W-1:0] vec,
    output logic [W-1:0] onehot,
    output logic         valid
);

    // Two's-complement trick isolates the lowest set bit.
    assign onehot = vec & (~vec + W'(1));
    assign valid  = |vec;

endmodule
`default_nettype wire

// File: rtl/vx_clone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vx_clone_sequencer
// Brief    : Mask-driven clone FSM copying the master register image into
//            slave lanes one per cycle, retrying on writeback conflicts.
// Revision : 1.0
// ============================================================================
module vx_clone_sequencer
    import vx_clone_sequencer_pkg::*;
#(
    parameter int NT           = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_clone_req,
    input  logic [NT-1:0]        in_clone_mask,
    input  logic                 in_wb_conflict,
    output logic [NT-1:0]        out_to_clone,
    output logic                 out_clone_stall,
    output logic                 out_busy,
    output logic                 out_done,
    output logic [$clog2(NT):0]  out_copied
);

    generate
        if (NT < 2) begin : g_nt_illegal
            $error("vx_clone_sequencer: NT must be at least 2");
        end
        if (DRAIN_CYCLES < 0 || DRAIN_CYCLES > 15) begin : g_drain_illegal
            $error("vx_clone_sequencer: DRAIN_CYCLES must be in 0..15");
        end
    endgenerate

    localparam logic [NT-1:0]      C_SLAVE_MASK = ~NT'(1);
    localparam logic [DRAIN_W-1:0] C_DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_state_nxt;
    logic [NT-1:0]        r_pend;
    logic [NT-1:0]        w_pend_nxt;
    logic [DRAIN_W-1:0]   r_drain;
    logic [DRAIN_W-1:0]   w_drain_nxt;
    logic [$clog2(NT):0]  r_copied;
    logic [$clog2(NT):0]  w_copied_nxt;
    logic [NT-1:0]        w_lane;
    logic                 w_lane_vld;
    logic [NT-1:0]        w_pend_cleared;

    vx_lowest_set #(
        .W      (NT)
    ) u_lowest_set (
        .vec    (r_pend),
        .onehot (w_lane),
        .valid  (w_lane_vld)
    );

    assign w_pend_cleared = r_pend & ~w_lane;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= CLONE_IDLE;
            r_pend   <= '0;
            r_drain  <= '0;
            r_copied <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pend   <= w_pend_nxt;
            r_drain  <= w_drain_nxt;
            r_copied <= w_copied_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pend_nxt   = r_pend;
        w_drain_nxt  = r_drain;
        w_copied_nxt = r_copied;
        case (r_state)
            CLONE_IDLE: begin
                if (in_clone_req) begin
                    w_pend_nxt   = in_clone_mask & C_SLAVE_MASK;
                    w_copied_nxt = '0;
                    w_state_nxt  = ((in_clone_mask & C_SLAVE_MASK) != '0) ? CLONE_COPY : CLONE_DONE;
                end
            end
            CLONE_COPY: begin
                if (!w_lane_vld) begin
                    w_state_nxt = CLONE_DONE;
                end else if (!in_wb_conflict) begin
                    w_pend_nxt   = w_pend_cleared;
                    w_copied_nxt = r_copied + 1'b1;
                    if (w_pend_cleared == '0) begin
                        w_drain_nxt = C_DRAIN_INIT;
                        w_state_nxt = (DRAIN_CYCLES == 0) ? CLONE_DONE : CLONE_DRAIN;
                    end
                end
            end
            CLONE_DRAIN: begin
                w_drain_nxt = r_drain - 1'b1;
                if (r_drain <= DRAIN_W'(1)) begin
                    w_drain_nxt = '0;
                    w_state_nxt = CLONE_DONE;
                end
            end
            default: begin
                w_state_nxt = CLONE_IDLE;
            end
        endcase
    end

    // Stall is gated by reset so a held request cannot leak through while in reset.
    always_comb begin
        out_to_clone    = '0;
        out_clone_stall = 1'b0;
        out_busy        = 1'b0;
        out_done        = 1'b0;
        case (r_state)
            CLONE_IDLE: begin
                out_clone_stall = in_clone_req & reset_n;
            end
            CLONE_COPY: begin
                out_clone_stall = 1'b1;
                out_busy        = 1'b1;
                if (!in_wb_conflict) begin
                    out_to_clone = w_lane;
                end
            end
            CLONE_DRAIN: begin
                out_clone_stall = 1'b1;
                out_busy        = 1'b1;
            end
            default: begin
                out_busy = 1'b1;
                out_done = 1'b1;
            end
        endcase
    end

    assign out_copied = r_copied;

endmodule
`default_nettype wire

// File: doc/vx_clone_sequencer.md
Name: vx_clone_sequencer

Overview:
- Sequences the thread-clone operation for the per-thread register file array: copies the master (warp 0, thread 0) register image into each selected slave thread register file, one lane per cycle.
- Produces the per-lane clone strobes and the decode-stage clone stall.
- Replaces the fixed countdown stall with a mask-driven FSM that is aware of writeback conflicts.
- Sits beside the register context block; driven by decode, and observes the writeback port.

Parameters:
- NT, 4, number of threads (lanes) per warp; lane 0 is the master and is never a clone target.
- DRAIN_CYCLES, 2, idle cycles after the last copy before the stall releases; range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_clone_req  in  1  decode holds a clone instruction; held high until out_clone_stall drops.
- in_clone_mask  in  NT  target lanes, sampled at accept; bit 0 ignored.
- in_wb_conflict  in  1  master register file written this cycle (writeback valid, warp 0, lane 0 valid, rd != 0).
- out_to_clone  out  NT  one-hot lane strobe; the slave copies the master image on the rising edge where its bit is set.
- out_clone_stall  out  1  freeze fetch/decode.
- out_busy  out  1  FSM not IDLE.
- out_done  out  1  single-cycle pulse in the DONE state.
- out_copied  out  $clog2(NT)+1  lanes copied by the current or last operation.

Behaviour:
- Reset (async assert, sync-to-clk deassert is external): state=IDLE, pending mask=0, drain count=0, out_copied=0. All outputs are 0.
- States: IDLE, COPY, DRAIN, DONE.
- IDLE:
  - If in_clone_req is 1: latch pend = in_clone_mask & ~1 and clear out_copied.
  - If pend is nonzero, go to COPY; if pend is zero, go straight to DONE.
  - out_clone_stall = in_clone_req (combinational), so the request cycle already stalls.
- COPY:
  - Select lane = lowest set bit of pend.
  - If in_wb_conflict = 0:
    - Drive out_to_clone[lane] = 1.
    - Clear that bit in pend and increment out_copied.
    - If pend becomes 0: go to DRAIN, with drain count = DRAIN_CYCLES, or go to DONE if DRAIN_CYCLES = 0.
  - If in_wb_conflict = 1: out_to_clone = 0, pend is unchanged, and the same lane retries next cycle. There is no timeout.
  - out_clone_stall = 1.
- DRAIN: decrement the drain count each cycle; go to DONE when the count reaches 1. out_clone_stall = 1.
- DONE:
  - out_done = 1 and out_clone_stall = 0, so the clone instruction advances this cycle. Next state is IDLE.
  - in_clone_req seen in DONE belongs to the current instruction and is ignored. A new request is accepted only from IDLE.
- out_to_clone: at most one bit set; always 0 outside COPY.
- Latency for k target lanes and no conflicts: stall cycles = 1 (IDLE) + k + DRAIN_CYCLES. DONE follows; total = k + DRAIN_CYCLES + 2 cycles from request to out_done.
- Boundaries:
  - A mask change during an operation has no effect.
  - Reset mid-COPY aborts immediately, leaving partially copied lanes copied, with all outputs 0 asynchronously.
  - If in_clone_req drops while busy (flush), the FSM still completes. The flush logic must not rely on abort.
  - NT=1 is illegal: the elaboration must fail with an error.

Decomposition:
- Shared definitions in VX_define.v: NT and NT_M1 (already defined there), plus new state encodings CLONE_IDLE=2'd0, CLONE_COPY=2'd1, CLONE_DRAIN=2'd2, CLONE_DONE=2'd3.
- One sub-module: vx_lowest_set, a combinational NT-bit priority encoder producing a one-hot output and a valid flag. It is reusable by the warp scheduler.

Test Plan:
- NT=4, DRAIN=2, mask=4'b1110, no conflict:
  - out_to_clone = 0010, 0100, 1000 on cycles 1-3.
  - Stall high for cycles 0-5; out_done pulses at cycle 6; out_copied = 3.
- Mask 4'b0001 (lane 0 only): straight to DONE; out_to_clone never set; out_done at cycle 1; out_copied = 0.
- Mask 4'b1010 with in_wb_conflict high on cycles 1-2:
  - No strobe on cycles 1-2.
  - 0010 on cycle 3, 1000 on cycle 4; out_done at cycle 7.
- reset_n pulsed low during the second COPY cycle of mask 1110:
  - All outputs go 0 immediately; state returns to IDLE.
  - After release, a new request with mask 0100 completes normally with out_copied = 1.
- DRAIN_CYCLES=0, mask 4'b0100: strobe 0100 at cycle 1, DONE at cycle 2. Back-to-back request accepted in the IDLE cycle 3, not in DONE.
